// File: rtl/rv_dmem_resp.sv
// rv_dmem_resp: data-memory responder for the core's dmem port.
// Word-organised RAM with byte/half/word access and load extension, plus a
// 16-byte MMIO window: console TX FIFO, cycle counter and halt register.
// Optional feature macro: RV_DMEM_CYCLE_CNT_EN (implements the CYCLE counter;
// when undefined the CYCLE register reads 0 and ignores writes).

`ifndef XLEN
`define XLEN 32
`endif

module rv_dmem_resp #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned CON_FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000
) (
    input  logic              i_dm_clk,
    input  logic              i_dm_rstn,
    input  logic [`XLEN-1:0]  i_dm_a,
    input  logic [`XLEN-1:0]  i_dm_wd,
    input  logic              i_dm_we,
    input  logic [2:0]        i_dm_bytectrl,
    output logic [`XLEN-1:0]  o_dm_rd,
    output logic              o_dm_con_valid,
    output logic [7:0]        o_dm_con_data,
    input  logic              i_dm_con_ready,
    output logic              o_dm_halt,
    output logic [31:0]       o_dm_halt_code
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(CON_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(CON_FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Address / access decode
    // ------------------------------------------------------------------
    logic          size_ok;
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [1:0]    mmio_off;
    logic          halt_q;
    logic [31:0]   halt_code_q;
    logic          wr_ok;
    logic          ram_wr;
    logic          mmio_wr;
    logic          push_req;
    logic          halt_wr;

    // Legal size codes; anything else reads 0 and drops the store.
    always_comb begin
        size_ok = 1'b0;
        case (i_dm_bytectrl)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
            default:                                size_ok = 1'b0;
        endcase
    end

    assign ram_hit  = (i_dm_a[31:AW+2] == '0);
    assign mmio_hit = (i_dm_a[31:4] == MMIO_BASE[31:4]);
    assign ram_idx  = i_dm_a[AW+1:2];
    assign mmio_off = i_dm_a[3:2];

    // Once halted every store is ignored, including further HALT writes.
    assign wr_ok    = i_dm_we & size_ok & ~halt_q;
    assign ram_wr   = wr_ok & ram_hit;
    assign mmio_wr  = wr_ok & ~ram_hit & mmio_hit;
    assign push_req = mmio_wr & (mmio_off == 2'd0);
    assign halt_wr  = mmio_wr & (mmio_off == 2'd3);

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH_WORDS];
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ram_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ram_rd;

    // Lane enables and replicated store data; 100/101 alias to byte/half.
    always_comb begin
        be    = 4'b0000;
        wdata = i_dm_wd;
        case (i_dm_bytectrl[1:0])
            2'b00: begin
                be    = 4'b0001 << i_dm_a[1:0];
                wdata = {4{i_dm_wd[7:0]}};
            end
            2'b01: begin
                be    = i_dm_a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_dm_wd[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Byte-lane writes on the clock edge; contents are never reset.
    always_ff @(posedge i_dm_clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign ram_word = mem[ram_idx];

    // Lane selection and sign/zero extension for loads.
    always_comb begin
        byte_sel = ram_word[7:0];
        case (i_dm_a[1:0])
            2'd0: byte_sel = ram_word[7:0];
            2'd1: byte_sel = ram_word[15:8];
            2'd2: byte_sel = ram_word[23:16];
            2'd3: byte_sel = ram_word[31:24];
            default: byte_sel = ram_word[7:0];
        endcase
        half_sel = i_dm_a[1] ? ram_word[31:16] : ram_word[15:0];
        ram_rd   = '0;
        case (i_dm_bytectrl)
            3'b000:  ram_rd = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ram_rd = {{16{half_sel[15]}}, half_sel};
            3'b010:  ram_rd = ram_word;
            3'b100:  ram_rd = {24'b0, byte_sel};
            3'b101:  ram_rd = {16'b0, half_sel};
            default: ram_rd = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Console TX FIFO
    // Handshake: a byte transfers on a rising edge where o_dm_con_valid
    // and i_dm_con_ready are both high; valid never depends on ready, and
    // data is stable while valid is high and ready is low.
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [CON_FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;

    assign fifo_full = (count == FIFO_FULL);
    assign pop       = o_dm_con_valid & i_dm_con_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok   = push_req & (~fifo_full | pop);

    // FIFO storage; only the pointers and count need reset.
    always_ff @(posedge i_dm_clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= i_dm_wd[7:0];
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge i_dm_clk or negedge i_dm_rstn) begin
        if (!i_dm_rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign o_dm_con_valid = (count != '0);
    assign o_dm_con_data  = fifo_mem[rd_ptr];

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_val;

`ifdef RV_DMEM_CYCLE_CNT_EN
    logic        cyc_wr;
    logic [31:0] cycle_q;

    assign cyc_wr = mmio_wr & (mmio_off == 2'd2);

    // Free-running count; a write clears it, halt freezes it.
    always_ff @(posedge i_dm_clk or negedge i_dm_rstn) begin
        if (!i_dm_rstn) begin
            cycle_q <= '0;
        end else if (cyc_wr) begin
            cycle_q <= '0;
        end else if (!halt_q) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // ------------------------------------------------------------------
    // Halt register
    // ------------------------------------------------------------------

    // First HALT write wins; wr_ok already masks later writes.
    always_ff @(posedge i_dm_clk or negedge i_dm_rstn) begin
        if (!i_dm_rstn) begin
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else if (halt_wr) begin
            halt_q      <= 1'b1;
            halt_code_q <= i_dm_wd;
        end
    end

    assign o_dm_halt      = halt_q;
    assign o_dm_halt_code = halt_code_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] mmio_rd;

    // MMIO registers are full words regardless of access size.
    always_comb begin
        mmio_rd = '0;
        case (mmio_off)
            2'd0: mmio_rd = '0;
            2'd1: mmio_rd = {16'b0, 8'(count), 5'b0, overflow,
                             (count == '0), fifo_full};
            2'd2: mmio_rd = cycle_val;
            2'd3: mmio_rd = {31'b0, halt_q};
            default: mmio_rd = '0;
        endcase
    end

    // Zero-latency load path: RAM wins, then MMIO, otherwise 0.
    always_comb begin
        o_dm_rd = '0;
        if (size_ok) begin
            if (ram_hit) begin
                o_dm_rd = ram_rd;
            end else if (mmio_hit) begin
                o_dm_rd = mmio_rd;
            end
        end
    end

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed bench for rv_dmem_resp: RAM access/extension, read-during-write,
// address boundaries, console FIFO with scoreboard, CYCLE and HALT.

module tb_rv_dmem_resp;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef RV_DMEM_CYCLE_CNT_EN
  localparam bit CYC_ON = 1'b1;
`else
  localparam bit CYC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [2:0]  bc;
  logic [31:0] rd;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        halt;
  logic [31:0] halt_code;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int n;

  // clock / reset block
  always #5 clk = ~clk;

  rv_dmem_resp dut (
    .i_dm_clk       (clk),
    .i_dm_rstn      (rst_n),
    .i_dm_a         (a),
    .i_dm_wd        (wd),
    .i_dm_we        (we),
    .i_dm_bytectrl  (bc),
    .o_dm_rd        (rd),
    .o_dm_con_valid (con_valid),
    .o_dm_con_data  (con_data),
    .i_dm_con_ready (con_ready),
    .o_dm_halt      (halt),
    .o_dm_halt_code (halt_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] ctl);
    a = addr; wd = data; bc = ctl; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [2:0] ctl,
                        input logic [31:0] expv);
    a = addr; bc = ctl; we = 1'b0;
    #1;
    check(tag, rd, expv);
  endtask

  // Push one console byte; the scoreboard decides acceptance from its own occupancy.
  task automatic push(input logic [7:0] data, input logic rdy);
    bit pop_now;
    @(posedge clk); #1;
    con_ready = rdy;
    pop_now = con_ready && (exp_q.size() != 0);
    if (exp_q.size() < 8 || pop_now) exp_q.push_back(data);
    a = BASE; wd = {24'b0, data}; bc = 3'b010; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    con_ready = 1'b1;
    n = 0;
    while (con_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    con_ready = 1'b0;
    check({tag, "_cycles"}, n, 32'd8);
    check({tag, "_valid"}, {31'b0, con_valid}, 32'd0);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  // scoreboard: compare each transferred console byte with the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && con_valid === 1'b1 && con_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL con_unexpected observed=0x%02h expected=no byte", con_data);
      end
      if (exp_q.size() != 0) check("con_data", {24'b0, con_data}, {24'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    a = '0; wd = '0; we = 1'b0; bc = 3'b010; con_ready = 1'b0; rst_n = 1'b0;
    #12;
    check("rst_con_valid", {31'b0, con_valid}, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_halt_code", halt_code, 32'd0);
    rd_chk("rst_con_stat", BASE + 32'h4, 3'b010, 32'h0000_0002);
    rd_chk("rst_cycle", BASE + 32'h8, 3'b010, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // byte/half/word access and extension
    wr(32'h10, 32'h8899_AABB, 3'b010);
    wr(32'h11, 32'h0000_00CC, 3'b000);
    rd_chk("lw_10", 32'h10, 3'b010, 32'h8899_CCBB);
    rd_chk("lb_11", 32'h11, 3'b000, 32'hFFFF_FFCC);
    rd_chk("lbu_11", 32'h11, 3'b100, 32'h0000_00CC);
    rd_chk("lh_12", 32'h12, 3'b001, 32'hFFFF_8899);
    rd_chk("lhu_13", 32'h13, 3'b101, 32'h0000_8899);
    wr(32'h14, 32'hDEAD_BEEF, 3'b010);
    wr(32'h16, 32'hAAAA_5566, 3'b001);
    rd_chk("sh_16", 32'h14, 3'b010, 32'h5566_BEEF);
    rd_chk("lh_14", 32'h14, 3'b001, 32'hFFFF_BEEF);
    rd_chk("lhu_14", 32'h14, 3'b101, 32'h0000_BEEF);
    rd_chk("lb_17", 32'h17, 3'b000, 32'h0000_0055);

    // read-during-write, illegal code, code 100 store
    wr(32'h40, 32'h1111_1111, 3'b010);
    a = 32'h40; wd = 32'h2222_2222; bc = 3'b010; we = 1'b1;
    #1;
    check("rdw_old", rd, 32'h1111_1111);
    @(posedge clk); #1;
    we = 1'b0;
    check("rdw_new", rd, 32'h2222_2222);
    wr(32'h40, 32'h3333_3333, 3'b011);
    rd_chk("bad_code_read", 32'h40, 3'b011, 32'd0);
    rd_chk("bad_code_nowrite", 32'h40, 3'b010, 32'h2222_2222);
    wr(32'h41, 32'h0000_00EE, 3'b100);
    rd_chk("sbu_as_sb", 32'h40, 3'b010, 32'h2222_EE22);

    // RAM boundaries and unmapped space
    wr(32'h0, 32'hA5A5_A5A5, 3'b010);
    wr(32'hFFC, 32'h0BAD_C0DE, 3'b010);
    wr(32'h1000, 32'hFFFF_FFFF, 3'b010);
    wr(32'h8000_0000, 32'h1234_5678, 3'b010);
    rd_chk("ram_first", 32'h0, 3'b010, 32'hA5A5_A5A5);
    rd_chk("ram_last", 32'hFFC, 3'b010, 32'h0BAD_C0DE);
    rd_chk("unmapped_1000", 32'h1000, 3'b010, 32'd0);
    rd_chk("unmapped_8000", 32'h8000_0000, 3'b010, 32'd0);

    // FIFO overflow then drain
    for (int i = 0; i < 9; i++) push(8'h41 + 8'(i), 1'b0);
    rd_chk("ovf_stat", BASE + 32'h4, 3'b010, 32'h0000_0805);
    rd_chk("con_data_reads0", BASE, 3'b010, 32'd0);
    check("ovf_head", {24'b0, con_data}, 32'h41);
    check("ovf_sb_len", exp_q.size(), 32'd8);
    drain("ovf_drain");
    rd_chk("ovf_sticky_stat", BASE + 32'h4, 3'b010, 32'h0000_0006);

    // full FIFO with simultaneous push and pop
    pulse_reset();
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i), 1'b0);
    rd_chk("full_stat", BASE + 32'h4, 3'b010, 32'h0000_0801);
    push(8'h5A, 1'b1);
    con_ready = 1'b0;
    rd_chk("pushpop_stat", BASE + 32'h4, 3'b010, 32'h0000_0801);
    check("pushpop_head", {24'b0, con_data}, 32'h51);
    drain("pushpop_drain");
    rd_chk("pushpop_end_stat", BASE + 32'h4, 3'b010, 32'h0000_0002);

    // cycle counter: any write clears it
    wr(BASE + 32'h8, 32'hDEAD_0000, 3'b010);
    repeat (100) @(posedge clk);
    #1;
    rd_chk("cycle_100", BASE + 32'h8, 3'b010, CYC_ON ? 32'd100 : 32'd0);

    // halt: first code sticks, later writes dropped, counter frozen
    pulse_reset();
    wr(32'h20, 32'hCAFE_F00D, 3'b010);
    push(8'h61, 1'b0);
    push(8'h62, 1'b0);
    push(8'h63, 1'b0);
    wr(BASE + 32'h8, 32'd0, 3'b010);
    wr(BASE + 32'hC, 32'd1, 3'b010);
    wr(BASE + 32'hC, 32'd2, 3'b010);
    wr(32'h20, 32'h1234_5678, 3'b010);
    wr(BASE, 32'h77, 3'b010);
    check("halt_set", {31'b0, halt}, 32'd1);
    check("halt_code_first", halt_code, 32'd1);
    rd_chk("halt_read", BASE + 32'hC, 3'b010, 32'd1);
    rd_chk("halt_ram_kept", 32'h20, 3'b010, 32'hCAFE_F00D);
    rd_chk("halt_con_stat", BASE + 32'h4, 3'b010, 32'h0000_0300);
    repeat (5) @(posedge clk);
    #1;
    rd_chk("halt_cycle_frozen", BASE + 32'h8, 3'b010, CYC_ON ? 32'd1 : 32'd0);
    con_ready = 1'b1;
    @(posedge clk); #1;
    con_ready = 1'b0;
    rd_chk("halt_drain_stat", BASE + 32'h4, 3'b010, 32'h0000_0200);

    // asynchronous reset mid-drain
    con_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, con_valid}, 32'd0);
    check("arst_halt", {31'b0, halt}, 32'd0);
    check("arst_halt_code", halt_code, 32'd0);
    rd_chk("arst_con_stat", BASE + 32'h4, 3'b010, 32'h0000_0002);
    exp_q.delete();
    con_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
